// File: rtl/dwc_pkg.sv
// Shared defaults for the command-path width converter.
// Narrow upstream command word and assembled wide beat widths.
package dwc_pkg;

   localparam int CMD_IN_W  = 32;
   localparam int CMD_OUT_W = 128;

endpackage

// File: rtl/dwc_cmd.sv
// Command-path upsizer: packs CMD_WORD_NUMBER narrow words into one wide beat,
// little-endian (first accepted word lands in the least significant slot).
module dwc_cmd
   import dwc_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH  = CMD_IN_W,
   parameter int OUTPUT_DATA_WIDTH = CMD_OUT_W,
   parameter int CMD_WORD_NUMBER   = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_cmd_valid,
   output logic                         fifo_cmd_ready,
   input  logic [INPUT_DATA_WIDTH-1:0]  fifo_cmd_wdata,
   output logic                         dwc_cmd_valid,
   input  logic                         dwc_cmd_ready,
   output logic [OUTPUT_DATA_WIDTH-1:0] dwc_cmd_wdata
);

   localparam int CW = (CMD_WORD_NUMBER > 1) ? $clog2(CMD_WORD_NUMBER) : 1;
   localparam logic [CW-1:0] LAST = CW'(CMD_WORD_NUMBER - 1);

   generate
      if (CMD_WORD_NUMBER < 1 ||
          (OUTPUT_DATA_WIDTH % INPUT_DATA_WIDTH) != 0 ||
          CMD_WORD_NUMBER != OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH) begin : g_bad_params
         $fatal(1, "dwc_cmd: CMD_WORD_NUMBER must equal OUTPUT_DATA_WIDTH/INPUT_DATA_WIDTH exactly");
      end
   endgenerate

   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         vld_q, vld_d;
   logic [OUTPUT_DATA_WIDTH-1:0] beat_q, beat_d;
   logic                         acc_in, acc_out;

   // Ready depends only on registered valid and downstream ready, never on fifo_cmd_valid.
   assign fifo_cmd_ready = !vld_q || dwc_cmd_ready;
   assign acc_in         = fifo_cmd_valid && fifo_cmd_ready;
   assign acc_out        = vld_q && dwc_cmd_ready;
   assign dwc_cmd_valid  = vld_q;
   assign dwc_cmd_wdata  = beat_q;

   always_comb begin
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      beat_d = beat_q;
      if (acc_out)
         vld_d = 1'b0;
      // A word accepted alongside a consumed beat always has cnt_q == 0,
      // so it naturally starts the next beat in slot 0.
      if (acc_in) begin
         beat_d[cnt_q*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = fifo_cmd_wdata;
         if (cnt_q == LAST) begin
            cnt_d = '0;
            vld_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         beat_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: tb/tb_dwc_cmd.sv
// Bench for dwc_cmd: directed scenarios plus random traffic against a
// word-queue reference model of the upsizer.
module tb_dwc_cmd;
   import dwc_pkg::*;

   localparam int IW = CMD_IN_W;
   localparam int OW = CMD_OUT_W;
   localparam int N  = OW / IW;

   logic          clk = 1'b0;
   logic          rst;
   logic          fv, fr, dv, dr;
   logic [IW-1:0] fd;
   logic [OW-1:0] dd;

   int checks = 0;
   int errors = 0;

   // Reference model: accepted words queue up until N are present, then form a beat.
   logic [IW-1:0] words[$];
   logic          m_vld;
   logic [OW-1:0] m_beat;
   int            beats_out;

   dwc_cmd #(
      .INPUT_DATA_WIDTH (IW),
      .OUTPUT_DATA_WIDTH(OW),
      .CMD_WORD_NUMBER  (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_cmd_valid(fv),
      .fifo_cmd_ready(fr),
      .fifo_cmd_wdata(fd),
      .dwc_cmd_valid (dv),
      .dwc_cmd_ready (dr),
      .dwc_cmd_wdata (dd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, clock, update model.
   task automatic tick(input logic v, input logic [IW-1:0] d, input logic r);
      logic m_rdy, a_in, a_out;
      fv = v; fd = d; dr = r;
      #1;
      m_rdy = !m_vld || r;
      chk("fifo_cmd_ready", OW'(fr), OW'(m_rdy));
      chk("dwc_cmd_valid", OW'(dv), OW'(m_vld));
      if (m_vld) chk("dwc_cmd_wdata", dd, m_beat);
      a_in  = v && m_rdy;
      a_out = m_vld && r;
      @(posedge clk);
      if (rst) begin
         words.delete();
         m_vld  = 1'b0;
         m_beat = '0;
      end else begin
         if (a_out) begin
            m_vld = 1'b0;
            beats_out++;
         end
         if (a_in) begin
            words.push_back(d);
            if (words.size() == N) begin
               for (int i = 0; i < N; i++) m_beat[i*IW +: IW] = words[i];
               m_vld = 1'b1;
               words.delete();
            end
         end
      end
      #1;
   endtask

   initial begin
      logic [IW-1:0] w0, w1, w2, w3;
      rst = 1'b1; fv = 1'b0; fd = '0; dr = 1'b0;
      m_vld = 1'b0; m_beat = '0; beats_out = 0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_valid", OW'(dv), OW'(1'b0));
      chk("reset_wdata", dd, '0);
      chk("reset_ready", OW'(fr), OW'(1'b1));

      // Gapped fill, downstream not ready
      tick(1'b1, 32'hAAAAAAAA, 1'b0);
      tick(1'b0, 32'h0, 1'b0);
      tick(1'b1, 32'hBBBBBBBB, 1'b0);
      tick(1'b0, 32'h0, 1'b0);
      tick(1'b1, 32'hCCCCCCCC, 1'b0);
      tick(1'b1, 32'hDDDDDDDD, 1'b0);
      chk("gap_valid", OW'(dv), OW'(1'b1));
      chk("gap_beat", dd, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      chk("gap_ready_low", OW'(fr), OW'(1'b0));

      // Backpressure: beat held, offered word not taken
      repeat (5) tick(1'b1, 32'hEEEEEEEE, 1'b0);
      chk("bp_beat_stable", dd, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      chk("bp_valid_held", OW'(dv), OW'(1'b1));
      tick(1'b1, 32'hEEEEEEEE, 1'b1);
      chk("bp_valid_drop", OW'(dv), OW'(1'b0));
      tick(1'b1, 32'h11111111, 1'b1);
      tick(1'b1, 32'h22222222, 1'b1);
      tick(1'b1, 32'h33333333, 1'b1);
      chk("bp_slot0_e", dd, 128'h33333333_22222222_11111111_EEEEEEEE);
      tick(1'b0, 32'h0, 1'b1);

      // Streaming with downstream always ready
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, IW'(i), 1'b1);
         if (i == 4) chk("stream_beat0", dd, 128'h00000004_00000003_00000002_00000001);
         if (i == 5) chk("stream_one_cycle", OW'(dv), OW'(1'b0));
         if (i == 8) chk("stream_beat1", dd, 128'h00000008_00000007_00000006_00000005);
      end
      tick(1'b0, 32'h0, 1'b1);
      chk("stream_drained", OW'(dv), OW'(1'b0));

      // Reset mid-collection discards partial words
      tick(1'b1, 32'h5A5A5A5A, 1'b0);
      tick(1'b1, 32'hA5A5A5A5, 1'b0);
      rst = 1'b1;
      tick(1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
      tick(1'b1, w0, 1'b0);
      tick(1'b1, w1, 1'b0);
      tick(1'b1, w2, 1'b0);
      chk("midrst_not_early", OW'(dv), OW'(1'b0));
      tick(1'b1, w3, 1'b0);
      chk("midrst_beat", dd, {w3, w2, w1, w0});
      tick(1'b0, 32'h0, 1'b1);

      // Held valid is accepted once per cycle
      tick(1'b1, 32'hAAAAAAAA, 1'b0);
      tick(1'b1, 32'hAAAAAAAA, 1'b0);
      tick(1'b1, 32'hBBBBBBBB, 1'b0);
      tick(1'b1, 32'hBBBBBBBB, 1'b0);
      chk("held_beat", dd, 128'hBBBBBBBB_BBBBBBBB_AAAAAAAA_AAAAAAAA);
      tick(1'b0, 32'h0, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         tick(logic'($urandom_range(0, 1)), IW'($urandom), logic'($urandom_range(0, 2) != 0));
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
